nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequences one external 4-bit ripple-carry adder slice to add two wide operands.
//  The wide add runs nibble by nibble over NIBBLES cycles, LSB nibble first.
//  Between nibbles the carry is held in a register.
//  The block sits between a requester (start/done handshake) and the shared adder slice.
//  It owns operand capture, nibble indexing, carry chaining and result assembly.
// PARAMETERS
//  NIBBLES   4   number of 4-bit slices per operand; operand width W = 4*NIBBLES (NIBBLES >= 1)
// PORTS
//  clk         in   1    clock; all state updates on the rising edge
//  rst         in   1    reset, synchronous, active-high
//  start       in   1    request a new add; sampled only in IDLE
//  a           in   W    operand A; captured on the accepted start
//  b           in   W    operand B; captured on the accepted start
//  c_in        in   1    carry-in; captured on the accepted start
//  busy        out  1    1 while in RUN
//  done        out  1    one-cycle pulse; sum/c_out are final
//  sum         out  W    result; held from done until the next accepted start
//  c_out       out  1    final carry-out; held like sum
//  slice_a     out  4    to adder slice: current nibble of captured A
//  slice_b     out  4    to adder slice: current nibble of captured B
//  slice_cin   out  1    to adder slice: carry register
//  slice_sum   in   4    from adder slice (combinational result)
//  slice_cout  in   1    from adder slice (combinational result)
// BEHAVIOUR
//  - Reset (rst=1 at an edge):
//      state=IDLE; busy=0; done=0; sum=0; c_out=0; idx=0; carry=0; operand regs=0.
//  - Reset mid-RUN aborts the add with no done pulse; the rule above applies.
//  - rst has priority over start.
//  - IDLE:
//      slice_a=0, slice_b=0, slice_cin=0.
//      start=1 at edge T: capture a, b; carry<=c_in; idx<=0; sum<=0; c_out<=0; go to RUN.
//  - RUN, cycles T+1 .. T+NIBBLES:
//      slice_a = A[4*idx+3:4*idx]; slice_b likewise; slice_cin = carry.
//      At each edge: sum[4*idx+3:4*idx] <= slice_sum; carry <= slice_cout; idx <= idx+1.
//      At the edge ending the cycle with idx=NIBBLES-1: c_out<=slice_cout; go to DONE.
//  - DONE, cycle T+NIBBLES+1:
//      done=1; busy=0; slice outputs 0; unconditionally go to IDLE.
//  - Latency: start sampled at edge T -> done high in cycle T+NIBBLES+1.
//      Throughput: one add per NIBBLES+2 cycles.
//  - start is ignored in RUN and DONE (not queued).
//      a, b and c_in may change freely after acceptance.
//  - idx counter is ceil(log2(NIBBLES)) bits, minimum 1; it never wraps within an add.
//  - Width rule: arithmetic is unsigned and modulo 2^W; c_out is bit W of a+b+c_in.
//  - The slice is combinational; its outputs must settle within one clk period.
//  - No other path from a, b or c_in to any output.
// TESTING (NIBBLES=4 unless noted; bench models the slice as {cout,sum}=sa+sb+cin)
//  1. a=16'hFFFF, b=16'h0001, c_in=0, start at T:
//       done only in cycle T+5; sum=16'h0000, c_out=1; busy high in T+1..T+4.
//  2. a=16'h1234, b=16'h4321, c_in=1:
//       sum=16'h5556, c_out=0.
//     Check slice_a per RUN cycle: 4,3,2,1.
//     Check slice_cin per RUN cycle: 1,0,0,0.
//  3. Second start during RUN (and again in DONE) with different operands:
//       ignored; first result delivered unchanged.
//     Start in the next IDLE cycle is accepted.
//  4. rst=1 at edge T+2 of an add:
//       next cycle busy=0, done=0, sum=0, c_out=0.
//     No done pulse follows; a new start completes normally.
//  5. NIBBLES=1: a=4'hF, b=4'hF, c_in=1:
//       done in cycle T+2; sum=4'hF, c_out=1.
//  6. 1000 random (a, b, c_in) with back-to-back starts:
//       every result matches a+b+c_in.
//     Exactly one done per accepted start.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : Adds two wide operands by driving one shared, external 4-bit
//                combinational adder slice nibble by nibble, LSB nibble first.
//                The carry between nibbles is held in a register.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NIBBLES       number of 4-bit slices per operand; W = 4*NIBBLES (>= 1)
//  Ports
//    clk           clock, rising edge
//    rst           synchronous active-high reset
//    start_i       request a new add (sampled only in IDLE)
//    a_i, b_i      W-bit operands, captured on the accepted start
//    c_in_i        carry-in, captured on the accepted start
//    busy_o        high while the nibble sequence runs
//    done_o        one-cycle pulse; sum_o/c_out_o are final
//    sum_o         W-bit result, held until the next accepted start
//    c_out_o       final carry-out, held like sum_o
//    slice_a_o     current nibble of captured A to the adder slice
//    slice_b_o     current nibble of captured B to the adder slice
//    slice_cin_o   carry register to the adder slice
//    slice_sum_i   adder slice sum (combinational)
//    slice_cout_i  adder slice carry-out (combinational)
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    input  logic                 c_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] sum_o,
    output logic                 c_out_o,
    output logic [3:0]           slice_a_o,
    output logic [3:0]           slice_b_o,
    output logic                 slice_cin_o,
    input  logic [3:0]           slice_sum_i,
    input  logic                 slice_cout_i
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;

    // Select the nibble addressed by idx_q. Written as a compare-per-nibble
    // mux so the index width never has to match the part-select arithmetic.
    always_comb begin
        w_nib_a = 4'd0;
        w_nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_nib_a = a_q[4*i +: 4];
                w_nib_b = b_q[4*i +: 4];
            end
        end
    end

    // Slice inputs are forced to zero outside RUN so the shared adder sees
    // quiet inputs while this block is idle or reporting.
    always_comb begin
        slice_a_o   = 4'd0;
        slice_b_o   = 4'd0;
        slice_cin_o = 1'b0;
        if (state_q == S_RUN) begin
            slice_a_o   = w_nib_a;
            slice_b_o   = w_nib_b;
            slice_cin_o = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = c_in_i;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[4*i +: 4] = slice_sum_i;
                    end
                end
                carry_d = slice_cout_i;
                if (idx_q == C_LAST_IDX) begin
                    // Hold idx on the final nibble so it never wraps.
                    cout_d  = slice_cout_i;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o  = (state_q == S_RUN);
    assign done_o  = (state_q == S_DONE);
    assign sum_o   = sum_q;
    assign c_out_o = cout_q;

endmodule
`default_nettype wire
